// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - two-entry skid-buffered ALU writeback stage with overflow exception counter
// Decodes ALU results into writeback/branch form at acceptance and delivers them in order.
module alu_result_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic        in_overflow,
    input  logic        in_isNotEqual,
    input  logic        in_isLessThan,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_kind,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_branch_taken,
    output logic [7:0]  exc_count
);

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
        logic        exc;
    } entry_t;

    localparam logic [2:0] KIND_ADD  = 3'd1;
    localparam logic [2:0] KIND_ADDI = 3'd2;
    localparam logic [2:0] KIND_SUB  = 3'd3;
    localparam logic [2:0] KIND_BNE  = 3'd4;
    localparam logic [2:0] KIND_BLT  = 3'd5;
    localparam logic [4:0] EXC_RD    = 5'd30;

    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    logic       main_valid_q, main_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       in_ready_q, in_ready_d;
    logic [7:0] exc_q, exc_d;
    entry_t     new_e;
    logic       accept;
    logic       out_hs;

    assign accept = in_valid && in_ready_q && !flush;
    assign out_hs = main_valid_q && out_ready;

    always_comb begin
        new_e.data  = in_result;
        new_e.rd    = in_rd;
        new_e.we    = (in_rd != 5'd0);
        new_e.taken = 1'b0;
        new_e.exc   = 1'b0;
        case (in_kind)
            KIND_ADD, KIND_ADDI, KIND_SUB: begin
                // Overflow is turned into a write of the exception cause code into x30.
                if (in_overflow) begin
                    new_e.data = {29'd0, in_kind};
                    new_e.rd   = EXC_RD;
                    new_e.we   = 1'b1;
                    new_e.exc  = 1'b1;
                end
            end
            KIND_BNE: begin
                new_e.we    = 1'b0;
                new_e.taken = in_isNotEqual;
            end
            KIND_BLT: begin
                new_e.we    = 1'b0;
                new_e.taken = in_isLessThan;
            end
            default: ;
        endcase
    end

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_hs) begin
            // Main is free next cycle: the older skid entry wins, otherwise take the new input.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_d       = new_e;
                main_valid_d = accept;
            end
        end else if (accept) begin
            skid_d       = new_e;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_comb begin
        exc_d = exc_q;
        if (out_hs && main_q.exc && (exc_q != 8'hFF)) begin
            exc_d = exc_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            exc_q        <= 8'd0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            exc_q        <= exc_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign out_valid        = main_valid_q;
    assign out_data         = main_valid_q ? main_q.data : 32'd0;
    assign out_rd           = main_valid_q ? main_q.rd : 5'd0;
    assign out_we           = main_valid_q && main_q.we;
    assign out_branch_taken = main_valid_q && main_q.taken;
    assign exc_count        = exc_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard bench for alu_result_stage
module tb_alu_result_stage;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [31:0] in_result;
    logic        in_overflow, in_isNotEqual, in_isLessThan;
    logic [4:0]  in_rd;
    logic [2:0]  in_kind;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_we, out_branch_taken;
    logic [7:0]  exc_count;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_cnt = 0;
    bit   mon_en = 0;
    bit   prev_stall = 0;
    logic [39:0] prev_out;
    bit   rnd_done;

    alu_result_stage dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_overflow(in_overflow), .in_isNotEqual(in_isNotEqual), .in_isLessThan(in_isLessThan),
        .in_rd(in_rd), .in_kind(in_kind),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .out_we(out_we), .out_branch_taken(out_branch_taken), .exc_count(exc_count)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input logic [2:0] k, input logic [31:0] r, input logic ovf,
                                   input logic ne, input logic lt, input logic [4:0] rd);
        exp_t e;
        case (k)
            3'd1, 3'd2, 3'd3: begin
                if (ovf) e = '{data: {29'd0, k}, rd: 5'd30, we: 1'b1, taken: 1'b0, exc: 1'b1};
                else     e = '{data: r, rd: rd, we: (rd != 0), taken: 1'b0, exc: 1'b0};
            end
            3'd4:    e = '{data: r, rd: rd, we: 1'b0, taken: ne, exc: 1'b0};
            3'd5:    e = '{data: r, rd: rd, we: 1'b0, taken: lt, exc: 1'b0};
            default: e = '{data: r, rd: rd, we: (rd != 0), taken: 1'b0, exc: 1'b0};
        endcase
        return e;
    endfunction

    always @(negedge clock) begin
        if (mon_en) begin
            vectors++;
            if (exc_count !== exp_cnt[7:0]) begin
                miscompares++;
                $display("FAIL exc_count: got %0d expected %0d at %0t", exc_count, exp_cnt, $time);
            end
            if (out_valid === 1'b0) begin
                vectors++;
                if ({out_data, out_rd, out_we, out_branch_taken} !== 39'd0) begin
                    miscompares++;
                    $display("FAIL idle_zero: got data=%h rd=%0d we=%b tk=%b expected all 0",
                             out_data, out_rd, out_we, out_branch_taken);
                end
            end
            if (reset) begin
                sb.delete();
                exp_cnt = 0;
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    vectors++;
                    if ({out_valid, out_data, out_rd, out_we, out_branch_taken} !== prev_out) begin
                        miscompares++;
                        $display("FAIL stall_stable: got %h expected %h", {out_valid, out_data, out_rd, out_we, out_branch_taken}, prev_out);
                    end
                end
                if (out_valid && out_ready) begin
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_output: got data=%h rd=%0d expected no entry", out_data, out_rd);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (out_data !== e.data || out_rd !== e.rd || out_we !== e.we || out_branch_taken !== e.taken) begin
                            miscompares++;
                            $display("FAIL sb_entry: got data=%h rd=%0d we=%b tk=%b expected data=%h rd=%0d we=%b tk=%b",
                                     out_data, out_rd, out_we, out_branch_taken, e.data, e.rd, e.we, e.taken);
                        end
                        if (e.exc && exp_cnt < 255) exp_cnt++;
                    end
                end
                prev_stall = out_valid && !out_ready && !flush;
                prev_out = {out_valid, out_data, out_rd, out_we, out_branch_taken};
                if (flush) sb.delete();
                else if (in_valid && in_ready)
                    sb.push_back(model(in_kind, in_result, in_overflow, in_isNotEqual, in_isLessThan, in_rd));
            end
        end
    end

    task automatic send(input logic [2:0] k, input logic [31:0] r, input logic ovf,
                        input logic ne, input logic lt, input logic [4:0] rd);
        int n = 0;
        logic ok;
        in_valid = 1'b1; in_kind = k; in_result = r; in_overflow = ovf;
        in_isNotEqual = ne; in_isLessThan = lt; in_rd = rd;
        do begin
            ok = in_ready && !flush;
            @(posedge clock); #2;
            n++;
        end while (!ok && n < 200);
        in_valid = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((out_valid || sb.size() != 0) && n < 500) begin
            @(posedge clock); #2;
            n++;
        end
        vectors++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got out_valid=%b pending=%0d expected 0/0", out_valid, sb.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 0; in_valid = 0; out_ready = 0;
        in_result = 0; in_overflow = 0; in_isNotEqual = 0; in_isLessThan = 0; in_rd = 0; in_kind = 0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || exc_count !== 8'd0 ||
            out_data !== 32'd0 || out_rd !== 5'd0 || out_we !== 1'b0 || out_branch_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b rdy=%b exc=%0d data=%h rd=%0d we=%b tk=%b expected 0 1 0 0 0 0 0",
                     out_valid, in_ready, exc_count, out_data, out_rd, out_we, out_branch_taken);
        end
        mon_en = 1;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        send(3'd1, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 5'd4);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'd5 || out_rd !== 5'd4 || out_we !== 1'b1) begin
            miscompares++;
            $display("FAIL add_basic: got v=%b data=%h rd=%0d we=%b expected 1 5 4 1", out_valid, out_data, out_rd, out_we);
        end
        drain();
    endtask

    task automatic test_sub_overflow();
        do_reset();
        out_ready = 1'b0;
        send(3'd3, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 5'd7);
        vectors++;
        if (out_data !== 32'd3 || out_rd !== 5'd30 || out_we !== 1'b1 || exc_count !== 8'd0) begin
            miscompares++;
            $display("FAIL sub_ovf: got data=%h rd=%0d we=%b exc=%0d expected 3 30 1 0", out_data, out_rd, out_we, exc_count);
        end
        out_ready = 1'b1;
        @(posedge clock); #2;
        vectors++;
        if (exc_count !== 8'd1) begin
            miscompares++;
            $display("FAIL sub_ovf_count: got %0d expected 1", exc_count);
        end
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(3'd0, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 5'd1);
        send(3'd2, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 5'd2);
        vectors++;
        if (in_ready !== 1'b0 || out_data !== 32'h1111_1111) begin
            miscompares++;
            $display("FAIL bp_full: got rdy=%b data=%h expected 0 11111111", in_ready, out_data);
        end
        in_valid = 1'b1; in_kind = 3'd1; in_result = 32'h3333_3333; in_rd = 5'd3; in_overflow = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        vectors++;
        if (in_ready !== 1'b0 || out_data !== 32'h1111_1111) begin
            miscompares++;
            $display("FAIL bp_hold: got rdy=%b data=%h expected 0 11111111", in_ready, out_data);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #2;
        vectors++;
        if (in_ready !== 1'b1 || out_data !== 32'h2222_2222) begin
            miscompares++;
            $display("FAIL bp_release: got rdy=%b data=%h expected 1 22222222", in_ready, out_data);
        end
        send(3'd1, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 5'd3);
        drain();
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        send(3'd4, 32'h0000_00AA, 1'b1, 1'b1, 1'b0, 5'd3);
        vectors++;
        if (out_branch_taken !== 1'b1 || out_we !== 1'b0) begin
            miscompares++;
            $display("FAIL bne_taken: got tk=%b we=%b expected 1 0", out_branch_taken, out_we);
        end
        send(3'd0, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 5'd0);
        vectors++;
        if (out_we !== 1'b0 || out_data !== 32'h55) begin
            miscompares++;
            $display("FAIL rd0_we: got we=%b data=%h expected 0 55", out_we, out_data);
        end
        send(3'd5, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 5'd8);
        send(3'd5, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 5'd8);
        send(3'd6, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 5'd9);
        vectors++;
        if (out_data !== 32'hDEAD_BEEF || out_rd !== 5'd9 || out_we !== 1'b1) begin
            miscompares++;
            $display("FAIL kind6_ovf: got data=%h rd=%0d we=%b expected deadbeef 9 1", out_data, out_rd, out_we);
        end
        send(3'd2, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
        drain();
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        send(3'd3, 32'h0, 1'b1, 1'b0, 1'b0, 5'd1);
        send(3'd0, 32'h0000_0BBB, 1'b0, 1'b0, 1'b0, 5'd5);
        in_valid = 1'b1; in_kind = 3'd0; in_result = 32'h0000_0CCC; in_rd = 5'd6;
        flush = 1'b1;
        @(posedge clock); #2;
        flush = 1'b0; in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || exc_count !== 8'd0) begin
            miscompares++;
            $display("FAIL flush_empty: got v=%b rdy=%b exc=%0d expected 0 1 0", out_valid, in_ready, exc_count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #2;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_ghost: got v=%b data=%h expected v=0", out_valid, out_data);
            end
        end
        out_ready = 1'b0;
        send(3'd2, 32'h0, 1'b1, 1'b0, 1'b0, 5'd1);
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clock); #2;
        flush = 1'b0;
        vectors++;
        if (exc_count !== 8'd1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_hs_count: got exc=%0d v=%b expected 1 0", exc_count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        time t0;
        out_ready = 1'b1;
        t0 = $time;
        for (int i = 0; i < 6; i++) send(3'd1, 32'h100 + i, 1'b0, 1'b0, 1'b0, 5'(10 + i));
        vectors++;
        if (($time - t0) != 60 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back: got %0t ns rdy=%b expected 60 ns rdy=1", $time - t0, in_ready);
        end
        drain();
    endtask

    task automatic test_random();
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 60; i++)
                    send(3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clock); #2;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) send(3'(1 + (i % 3)), 32'h0, 1'b1, 1'b0, 1'b0, 5'd2);
        drain();
        vectors++;
        if (exc_count !== 8'd255) begin
            miscompares++;
            $display("FAIL saturate: got %0d expected 255", exc_count);
        end
        out_ready = 1'b0;
        send(3'd1, 32'h0, 1'b1, 1'b0, 1'b0, 5'd2);
        send(3'd0, 32'h7, 1'b0, 1'b0, 1'b0, 5'd2);
        do_reset();
        vectors++;
        if (exc_count !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_midstream: got exc=%0d v=%b rdy=%b expected 0 0 1", exc_count, out_valid, in_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub_overflow();
        test_backpressure();
        test_branch();
        test_flush();
        test_back_to_back();
        test_random();
        test_saturation();
        @(posedge clock); #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
